req_client4: RTL and testbench

- Requester-side companion to the team's 4-way fixed-priority grant selector (4-bit req/en in, one-hot gnt out, bit 3 highest).
- Collects per-channel request events into pending counters and drives req[3:0] and en into the selector.
- Samples the selector's combinational gnt each clock and retires one pending request per valid grant.
- Tracks per-channel wait time for starvation, and flags protocol violations on gnt.

---
 rtl/req_client4.sv | 133 +++++++++++++
 tb/tb_req_client4.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/req_client4.sv
// req_client4: requester-side companion to a 4-way fixed-priority grant
// selector. Per-channel pending counters turn push events into a request
// vector, sampled grants retire one request each, per-channel wait counters
// report starvation, and malformed grant vectors raise a sticky error.
module req_client4 #(
    parameter int CNT_W        = 3,
    parameter int WAIT_W       = 8,
    parameter int STARVE_LIMIT = 16,
    parameter int TOT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       push,
    input  logic [3:0]       gnt,
    output logic [3:0]       req,
    output logic             en,
    output logic [3:0]       full,
    output logic [3:0]       starve,
    output logic [3:0]       ovf,
    output logic             err,
    output logic [TOT_W-1:0] tot_gnt
);

    localparam logic [CNT_W-1:0]  PMAX      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  PZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  PONE      = CNT_W'(1);
    localparam logic [WAIT_W-1:0] WMAX      = {WAIT_W{1'b1}};
    localparam logic [WAIT_W-1:0] WZERO     = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] WONE      = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] STARVE_TH = WAIT_W'(STARVE_LIMIT);
    localparam logic [TOT_W-1:0]  TONE      = TOT_W'(1);

    // True when exactly one bit of the 4-bit vector is set.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

    logic [CNT_W-1:0]  pend_r     [4];
    logic [CNT_W-1:0]  pend_nxt_s [4];
    logic [WAIT_W-1:0] wait_r     [4];
    logic [WAIT_W-1:0] wait_nxt_s [4];
    logic [3:0]        ovf_r;
    logic [3:0]        ovf_nxt_s;
    logic              err_r;
    logic [TOT_W-1:0]  tot_r;
    logic              gnt_bad_s;
    logic [3:0]        grant_s;

    // Decode request/full/starve status purely from registered counters.
    always_comb begin
        req    = 4'b0000;
        full   = 4'b0000;
        starve = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            req[i]    = (pend_r[i] != PZERO);
            full[i]   = (pend_r[i] == PMAX);
            starve[i] = (wait_r[i] >= STARVE_TH);
        end
    end

    assign en      = |req;
    assign ovf     = ovf_r;
    assign err     = err_r;
    assign tot_gnt = tot_r;

    // Classify the sampled grant: idle, one valid grant, or protocol error.
    always_comb begin
        gnt_bad_s = 1'b0;
        grant_s   = 4'b0000;
        if (gnt == 4'b0000) begin
            gnt_bad_s = 1'b0;
        end else if (!is_onehot4(gnt) || ((gnt & ~req) != 4'b0000)) begin
            gnt_bad_s = 1'b1;
        end else begin
            grant_s = gnt;
        end
    end

    // Per-channel next pending count, overflow flag and wait counter.
    always_comb begin
        pend_nxt_s = pend_r;
        wait_nxt_s = wait_r;
        ovf_nxt_s  = ovf_r;
        for (int i = 0; i < 4; i++) begin
            case ({push[i], grant_s[i]})
                2'b11: pend_nxt_s[i] = pend_r[i];
                2'b10: begin
                    if (full[i]) begin
                        ovf_nxt_s[i] = 1'b1;
                    end else begin
                        pend_nxt_s[i] = pend_r[i] + PONE;
                    end
                end
                2'b01: pend_nxt_s[i] = pend_r[i] - PONE;
                default: pend_nxt_s[i] = pend_r[i];
            endcase

            if (grant_s[i] || (pend_nxt_s[i] == PZERO)) begin
                wait_nxt_s[i] = WZERO;
            end else if (req[i]) begin
                wait_nxt_s[i] = (wait_r[i] == WMAX) ? WMAX : (wait_r[i] + WONE);
            end else begin
                wait_nxt_s[i] = WZERO;
            end
        end
    end

    // State registers; reset wipes pending work and sticky flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                pend_r[i] <= PZERO;
                wait_r[i] <= WZERO;
            end
            ovf_r <= 4'b0000;
            err_r <= 1'b0;
            tot_r <= {TOT_W{1'b0}};
        end else begin
            for (int i = 0; i < 4; i++) begin
                pend_r[i] <= pend_nxt_s[i];
                wait_r[i] <= wait_nxt_s[i];
            end
            ovf_r <= ovf_nxt_s;
            err_r <= err_r | gnt_bad_s;
            if (grant_s != 4'b0000) begin
                tot_r <= tot_r + TONE;
            end else begin
                tot_r <= tot_r;
            end
        end
    end

endmodule

// File: tb/tb_req_client4.sv
// Bench for req_client4: directed scenarios followed by random traffic,
// every cycle compared against a counter-level model of the channel rules.
module tb_req_client4;

    logic        clock;
    logic        reset;
    logic [3:0]  push;
    logic [3:0]  gnt;
    logic [3:0]  req;
    logic        en;
    logic [3:0]  full;
    logic [3:0]  starve;
    logic [3:0]  ovf;
    logic        err;
    logic [15:0] tot_gnt;

    int n_pass  = 0;
    int n_total = 0;

    // model state
    int       m_pend [4];
    int       m_wait [4];
    bit [3:0] m_ovf;
    bit       m_err;
    int       m_tot;

    req_client4 dut (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .gnt     (gnt),
        .req     (req),
        .en      (en),
        .full    (full),
        .starve  (starve),
        .ovf     (ovf),
        .err     (err),
        .tot_gnt (tot_gnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Apply one clock edge of the channel rules to the model.
    task automatic model_clk(input logic [3:0] p, input logic [3:0] g, input logic r);
        bit [3:0] mreq;
        bit       bad;
        bit       any_g;
        int       np;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = 0;
                m_wait[i] = 0;
            end
            m_ovf = 4'b0000;
            m_err = 1'b0;
            m_tot = 0;
        end else begin
            for (int i = 0; i < 4; i++) mreq[i] = (m_pend[i] != 0);
            bad   = (g != 4'b0000) && (($countones(g) != 1) || ((g & ~mreq) != 4'b0000));
            any_g = 1'b0;
            if (bad) m_err = 1'b1;
            for (int i = 0; i < 4; i++) begin
                bit gi;
                gi = !bad && g[i];
                np = m_pend[i] + (p[i] ? 1 : 0) - (gi ? 1 : 0);
                if (np > 7) begin
                    np = 7;
                    m_ovf[i] = 1'b1;
                end
                if (gi || np == 0) m_wait[i] = 0;
                else if (m_pend[i] != 0) m_wait[i] = (m_wait[i] >= 255) ? 255 : m_wait[i] + 1;
                else m_wait[i] = 0;
                m_pend[i] = np;
                if (gi) any_g = 1'b1;
            end
            if (any_g) m_tot = (m_tot + 1) % 65536;
        end
    endtask

    // Compare every output against the model.
    task automatic check_all();
        logic [3:0] e_req;
        logic [3:0] e_full;
        logic [3:0] e_starve;
        for (int i = 0; i < 4; i++) begin
            e_req[i]    = (m_pend[i] != 0);
            e_full[i]   = (m_pend[i] == 7);
            e_starve[i] = (m_wait[i] >= 16);
        end
        chk("req",     {28'd0, req},     {28'd0, e_req});
        chk("en",      {31'd0, en},      {31'd0, (e_req != 4'b0000)});
        chk("full",    {28'd0, full},    {28'd0, e_full});
        chk("starve",  {28'd0, starve},  {28'd0, e_starve});
        chk("ovf",     {28'd0, ovf},     {28'd0, m_ovf});
        chk("err",     {31'd0, err},     {31'd0, m_err});
        chk("tot_gnt", {16'd0, tot_gnt}, m_tot);
    endtask

    task automatic step(input logic [3:0] p, input logic [3:0] g, input logic r);
        push  = p;
        gnt   = g;
        reset = r;
        @(posedge clock);
        model_clk(p, g, r);
        #1;
        check_all();
    endtask

    // Fixed-priority selector behaviour on the model's request state.
    function automatic logic [3:0] prio_gnt();
        logic [3:0] v;
        v = 4'b0000;
        for (int i = 3; i >= 0; i--) begin
            if (v == 4'b0000 && m_pend[i] != 0) v[i] = 1'b1;
        end
        return v;
    endfunction

    initial begin
        logic [3:0] p;
        logic [3:0] g;
        logic       r;
        int         sel;

        push  = 4'b0000;
        gnt   = 4'b0000;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0;
            m_wait[i] = 0;
        end
        m_ovf = 4'b0000;
        m_err = 1'b0;
        m_tot = 0;

        // reset and idle
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0000, 1'b1);
        chk("reset_tot", {16'd0, tot_gnt}, 32'd0);
        for (int k = 0; k < 5; k++) step(4'b0000, 4'b0000, 1'b0);
        chk("idle_req", {28'd0, req}, 32'd0);

        // single request loop
        step(4'b0001, 4'b0000, 1'b0);
        chk("single_req_up", {28'd0, req}, 32'd1);
        step(4'b0000, 4'b0001, 1'b0);
        chk("single_req_down", {28'd0, req}, 32'd0);
        chk("single_tot", {16'd0, tot_gnt}, 32'd1);
        step(4'b0000, 4'b0000, 1'b0);

        // fill and overflow channel 2
        step(4'b0000, 4'b0000, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            step(4'b0100, 4'b0000, 1'b0);
            if (k == 6) chk("full_before_7", {28'd0, full}, 32'd0);
            if (k == 7) chk("full_at_7", {28'd0, full}, 32'd4);
            if (k == 7) chk("ovf_at_7", {28'd0, ovf}, 32'd0);
            if (k == 8) chk("ovf_at_8", {28'd0, ovf}, 32'd4);
        end
        step(4'b0100, 4'b0100, 1'b0);
        chk("full_push_grant", {28'd0, full}, 32'd4);
        chk("tot_push_grant", {16'd0, tot_gnt}, 32'd1);

        // contention: channel 3 hogs the fixed-priority selector
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b1001, 4'b0000, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            step(4'b1000, prio_gnt(), 1'b0);
            if (k == 15) chk("starve_15", {31'd0, starve[0]}, 32'd0);
            if (k == 16) chk("starve_16", {31'd0, starve[0]}, 32'd1);
        end
        step(4'b0000, prio_gnt(), 1'b0);
        step(4'b0000, prio_gnt(), 1'b0);
        chk("starve_clear", {31'd0, starve[0]}, 32'd0);

        // protocol errors
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0011, 4'b0000, 1'b0);
        step(4'b0000, 4'b0011, 1'b0);
        chk("multi_gnt_err", {31'd0, err}, 32'd1);
        chk("multi_gnt_req", {28'd0, req}, 32'd3);
        step(4'b0000, 4'b0000, 1'b1);
        step(4'b0000, 4'b0100, 1'b0);
        chk("idle_gnt_err", {31'd0, err}, 32'd1);

        // reset in mid-operation, with a push in the same cycle
        step(4'b0000, 4'b0000, 1'b1);
        for (int k = 0; k < 8; k++) begin
            p = {1'b1, 1'b0, (k < 5), (k < 3)};
            step(p, 4'b0000, 1'b0);
        end
        chk("pre_reset_ovf", {28'd0, ovf}, 32'd8);
        step(4'b1111, 4'b0000, 1'b1);
        chk("mid_reset_req", {28'd0, req}, 32'd0);
        chk("mid_reset_ovf", {28'd0, ovf}, 32'd0);
        step(4'b0000, 4'b0000, 1'b0);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            sel = $urandom_range(0, 99);
            r   = ($urandom_range(0, 199) == 0);
            p   = 4'($urandom) & 4'($urandom);
            if (sel < 70)      g = prio_gnt();
            else if (sel < 88) g = 4'b0000;
            else if (sel < 97) g = 4'($urandom);
            else begin
                g = prio_gnt();
                r = 1'b1;
            end
            step(p, g, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
